// File: rtl/acq_sequencer.sv
// ---------------------------------------------------------------------------
// acq_sequencer
//
// Command-driven acquisition controller between the UART receiver, the ADC
// sample stream, the waveform buffer and the UART transmitter.
//
// An 'A' (0x41) command arms a capture of SAMPLES ADC samples into the
// buffer. The block then requests serial readout and waits for the
// transmitter to finish. It then counts the waveform and holds off for
// HOLDOFF cycles before another capture may be armed. 'S' (0x53) aborts a
// capture in progress.
//
// Optional feature (compile-time macro ACQ_CONTINUOUS_EN):
//   When defined, 'C' (0x43) arms like 'A' and also sets a continuous flag.
//   While the flag is set, the block re-enters CAPTURE directly when HOLDOFF
//   expires. 'S' or reset clears the flag.
//   When undefined, 'C' is ignored, and HOLDOFF always returns to IDLE.
//
// Parameters:
//   SAMPLES  samples per waveform, must equal 2**ADDR_W
//   ADDR_W   buffer address width
//   HOLDOFF  cycles spent in HOLDOFF after readout (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   cmd_valid  one-cycle strobe qualifying cmd_byte
//   cmd_byte   received command byte
//   adc_valid  one-cycle strobe per ADC sample
//   tx_done    one-cycle strobe, waveform transmission complete
//   acquire    low while capturing
//   wr_en      buffer write strobe
//   wr_addr    buffer write address
//   tx_start   one-cycle readout request
//   wavenum    count of completed waveforms (wraps at 16 bits)
//   busy       high in any state except IDLE
// ---------------------------------------------------------------------------
module acq_sequencer #(
    parameter int SAMPLES = 1024,
    parameter int ADDR_W  = 10,
    parameter int HOLDOFF = 18040
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd_byte,
    input  logic              adc_valid,
    input  logic              tx_done,
    output logic              acquire,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              tx_start,
    output logic [15:0]       wavenum,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_READOUT,
        ST_HOLDOFF
    } state_t;

    localparam int                HOLD_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SAMPLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);
    localparam logic [7:0]        CMD_ARM   = 8'h41;
    localparam logic [7:0]        CMD_STOP  = 8'h53;
`ifdef ACQ_CONTINUOUS_EN
    localparam logic [7:0]        CMD_CONT  = 8'h43;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              start_pend_q, start_pend_d;
    logic              acquire_q, acquire_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              tx_start_q, tx_start_d;
    logic [15:0]       wavenum_q, wavenum_d;
    logic              busy_q, busy_d;
`ifdef ACQ_CONTINUOUS_EN
    logic              cont_q, cont_d;
`endif

    logic cmd_arm;
    logic cmd_stop;
    logic cmd_cont;
    logic rearm;

    // Command decode and the decision whether an expiring holdoff goes
    // straight back into a capture. A coincident 'S' takes priority.
    always_comb begin
        cmd_arm  = cmd_valid && (cmd_byte == CMD_ARM);
        cmd_stop = cmd_valid && (cmd_byte == CMD_STOP);
`ifdef ACQ_CONTINUOUS_EN
        cmd_cont = cmd_valid && (cmd_byte == CMD_CONT);
        rearm    = cont_q && !cmd_stop;
`else
        cmd_cont = 1'b0;
        rearm    = 1'b0;
`endif
    end

    // Next-state and next-output logic. The outputs are derived from the
    // next state, so they change on the same edge as the state register.
    // tx_start is delayed through start_pend so that it lands one cycle
    // after READOUT is entered.
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        start_pend_d = 1'b0;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        tx_start_d   = start_pend_q;
        wavenum_d    = wavenum_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_arm || cmd_cont) begin
                    state_d      = ST_CAPTURE;
                    sample_cnt_d = '0;
                end
            end
            ST_CAPTURE: begin
                if (cmd_stop) begin
                    state_d = ST_IDLE;
                end else if (adc_valid) begin
                    wr_en_d      = 1'b1;
                    wr_addr_d    = sample_cnt_q;
                    sample_cnt_d = sample_cnt_q + ADDR_W'(1);
                    if (sample_cnt_q == LAST_ADDR) begin
                        state_d      = ST_READOUT;
                        start_pend_d = 1'b1;
                    end
                end
            end
            ST_READOUT: begin
                if (tx_done) begin
                    state_d    = ST_HOLDOFF;
                    wavenum_d  = wavenum_q + 16'd1;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    if (rearm) begin
                        state_d      = ST_CAPTURE;
                        sample_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        acquire_d = (state_d != ST_CAPTURE);
        busy_d    = (state_d != ST_IDLE);
    end

`ifdef ACQ_CONTINUOUS_EN
    // The continuous flag is set only by 'C' accepted in IDLE, and any 'S'
    // clears it regardless of the state.
    always_comb begin
        cont_d = cont_q;
        if (cmd_stop) begin
            cont_d = 1'b0;
        end else if ((state_q == ST_IDLE) && cmd_cont) begin
            cont_d = 1'b1;
        end
    end
`endif

    // State and registered outputs. Reset also drops a pending tx_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sample_cnt_q <= '0;
            hold_cnt_q   <= '0;
            start_pend_q <= 1'b0;
            acquire_q    <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            tx_start_q   <= 1'b0;
            wavenum_q    <= 16'd0;
            busy_q       <= 1'b0;
`ifdef ACQ_CONTINUOUS_EN
            cont_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            start_pend_q <= start_pend_d;
            acquire_q    <= acquire_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            tx_start_q   <= tx_start_d;
            wavenum_q    <= wavenum_d;
            busy_q       <= busy_d;
`ifdef ACQ_CONTINUOUS_EN
            cont_q       <= cont_d;
`endif
        end
    end

    assign acquire  = acquire_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign tx_start = tx_start_q;
    assign wavenum  = wavenum_q;
    assign busy     = busy_q;

endmodule
